// File: rtl/dot_product_unit_pkg.sv
// Shared definitions for the streaming dot-product unit.
package dot_product_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dpu_state_e;

  localparam int unsigned DPU_WIDTH     = 16;
  localparam int unsigned DPU_ACC_WIDTH = 40;
  localparam int unsigned DPU_LEN_WIDTH = 8;

endpackage

// File: rtl/Accum.sv
// Loadable accumulator; adds offset each enabled cycle, wrapping modulo 2^WIDTH.
module Accum #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] q
);

  // Running sum: async clear, load wins over add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= q + offset;
    end
  end

endmodule

// File: rtl/Counter.sv
// Loadable up/down counter. Load takes priority over count enable.
module Counter #(
  parameter int unsigned WIDTH = 8,
  parameter bit          UP    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Count register: async clear, load, then step in the configured direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      if (UP) begin
        q <= q + WIDTH'(1);
      end else begin
        q <= q - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/dot_product_unit.sv
// Streaming signed dot-product engine: accepts length operand pairs over a
// valid/ready stream and presents sum(a*b) on a valid/ready output.
module dot_product_unit
  import dot_product_unit_pkg::*;
#(
  parameter int unsigned WIDTH     = DPU_WIDTH,
  parameter int unsigned ACC_WIDTH = DPU_ACC_WIDTH,
  parameter int unsigned LEN_WIDTH = DPU_LEN_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [LEN_WIDTH-1:0]        length,
  input  logic signed [WIDTH-1:0]     a_data,
  input  logic signed [WIDTH-1:0]     b_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  dpu_state_e                  r_state;
  dpu_state_e                  w_state_next;
  logic                        w_load;
  logic                        w_hs;
  logic                        w_last;
  logic [LEN_WIDTH-1:0]        w_count;
  logic signed [2*WIDTH-1:0]   w_mult;
  logic signed [2*WIDTH-1:0]   r_prod;
  logic                        r_prod_valid;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic [ACC_WIDTH-1:0]        w_sum;

  assign w_load = (r_state == IDLE) && start;
  assign w_hs   = in_valid && (r_state == ACCUM);
  assign w_last = (w_count == LEN_WIDTH'(1));

  // Operands are widened before multiplying so the full signed product is kept.
  assign w_mult     = (2*WIDTH)'(a_data) * (2*WIDTH)'(b_data);
  assign w_prod_ext = ACC_WIDTH'(r_prod);

  Counter #(
    .WIDTH (LEN_WIDTH),
    .UP    (1'b0)
  ) u_counter (
    .clk  (clock),
    .rst  (reset),
    .load (w_load),
    .en   (w_hs),
    .d    (length),
    .q    (w_count)
  );

  Accum #(
    .WIDTH (ACC_WIDTH)
  ) u_accum (
    .clk    (clock),
    .rst    (reset),
    .load   (w_load),
    .en     (r_prod_valid),
    .d      ('0),
    .offset (w_prod_ext),
    .q      (w_sum)
  );

  // Product pipeline stage: captures a*b on each accepted pair.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prod       <= '0;
      r_prod_valid <= 1'b0;
    end else begin
      if (w_hs) begin
        r_prod <= w_mult;
      end
      r_prod_valid <= w_hs;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    busy         = 1'b1;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = (length != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (w_hs && w_last) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = w_sum;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dot_product_unit.sv
// Self-checking bench for dot_product_unit (default and narrow configurations).
module tb_dot_product_unit;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 40;
  localparam int unsigned LW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [LW-1:0] length;
  logic [W-1:0]  a_data, b_data;
  logic          in_valid, in_ready;
  logic [AW-1:0] out_data;
  logic          out_valid, out_ready, busy;

  logic          start8;
  logic [7:0]    length8;
  logic [7:0]    a8, b8;
  logic          in_valid8, in_ready8;
  logic [15:0]   out_data8;
  logic          out_valid8, out_ready8, busy8;

  int n_assert = 0;
  int n_fail   = 0;
  int qa[$];
  int qb[$];

  dot_product_unit u_dut (
    .clock     (clk),
    .reset     (rst),
    .start     (start),
    .length    (length),
    .a_data    (a_data),
    .b_data    (b_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  dot_product_unit #(
    .WIDTH     (8),
    .ACC_WIDTH (16),
    .LEN_WIDTH (8)
  ) u_dut8 (
    .clock     (clk),
    .reset     (rst),
    .start     (start8),
    .length    (length8),
    .a_data    (a8),
    .b_data    (b8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .out_data  (out_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .busy      (busy8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer sum of products, reduced modulo 2^AW.
  function automatic logic [AW-1:0] ref_dot();
    longint s;
    s = 0;
    foreach (qa[i]) s += longint'(qa[i]) * longint'(qb[i]);
    return s[AW-1:0];
  endfunction

  // One complete transaction on the default-width unit using qa/qb.
  task automatic run_main(input string tag, input int unsigned len,
                          input int unsigned gap_pct, input int unsigned hold);
    logic [AW-1:0] expv;
    int unsigned   idx;
    int unsigned   cyc;
    bit            v;
    bit            hs;
    expv   = ref_dot();
    start  = 1'b1;
    length = LW'(len);
    step();
    start  = 1'b0;
    length = LW'($urandom);
    if (len == 0) begin
      check({tag, "_len0_in_ready"}, 64'(in_ready), 64'd0);
    end else begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      idx = 0;
      cyc = 0;
      while (idx < len && cyc < 4 * len + 50) begin
        v        = ($urandom_range(99) >= gap_pct);
        in_valid = v;
        if (v) begin
          a_data = W'(qa[idx]);
          b_data = W'(qb[idx]);
        end else begin
          a_data = W'($urandom);
          b_data = W'($urandom);
        end
        hs = v && in_ready;
        step();
        cyc++;
        if (hs) idx++;
      end
      in_valid = 1'b0;
      a_data   = W'($urandom);
      b_data   = W'($urandom);
      check({tag, "_hs_count"}, 64'(idx), 64'(len));
      check({tag, "_drain_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_drain_out_valid"}, 64'(out_valid), 64'd0);
      step();
    end
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_out_data"}, 64'(out_data), 64'(expv));
    out_ready = 1'b0;
    for (int k = 0; k < int'(hold); k++) begin
      start  = 1'($urandom_range(1));
      length = LW'($urandom);
      step();
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_data"}, 64'(out_data), 64'(expv));
    end
    start     = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_data"}, 64'(out_data), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    step();
    check({tag, "_start_ignored"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    length     = '0;
    a_data     = '0;
    b_data     = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    start8     = 1'b0;
    length8    = '0;
    a8         = '0;
    b8         = '0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    repeat (2) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    qa = '{1, 2, 3, 4};
    qb = '{5, 6, 7, 8};
    run_main("t1_basic", 4, 0, 0);
    check("t1_expected_70", 64'(ref_dot()), 64'd70);

    qa = '{-3, 127};
    qb = '{5, -2};
    run_main("t2_gaps", 2, 60, 0);

    qa = {};
    qb = {};
    run_main("t3_len0", 0, 0, 0);

    qa = '{1, 1, 1};
    qb = '{1, 1, 1};
    run_main("t4_backpressure", 3, 0, 5);

    for (int r = 0; r < 6; r++) begin
      int unsigned len;
      len = $urandom_range(1, 20);
      qa = {};
      qb = {};
      for (int i = 0; i < int'(len); i++) begin
        qa.push_back(int'($urandom_range(65535)) - 32768);
        qb.push_back(int'($urandom_range(65535)) - 32768);
      end
      run_main("rand", len, 30, $urandom_range(3));
    end

    qa = {};
    qb = {};
    for (int i = 0; i < 255; i++) begin
      qa.push_back(-32768);
      qb.push_back(-32768);
    end
    run_main("maxlen_extreme", 255, 0, 0);

    // Reset in the middle of a four-element run.
    start  = 1'b1;
    length = LW'(4);
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    a_data   = W'(100);
    b_data   = W'(100);
    repeat (2) step();
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_in_ready", 64'(in_ready), 64'd0);
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_out_data", 64'(out_data), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    check("t6_idle_after_rst", 64'(busy), 64'd0);
    qa = '{7};
    qb = '{6};
    run_main("t6_recover", 1, 0, 0);

    // Narrow configuration: wraps modulo 2^16.
    start8  = 1'b1;
    length8 = 8'd3;
    step();
    start8    = 1'b0;
    in_valid8 = 1'b1;
    a8        = 8'h80;
    b8        = 8'h80;
    repeat (3) step();
    in_valid8 = 1'b0;
    check("t5_drain_valid", 64'(out_valid8), 64'd0);
    step();
    check("t5_out_valid", 64'(out_valid8), 64'd1);
    check("t5_out_data", 64'(out_data8), 64'(16'hC000));
    step();
    check("t5_idle_valid", 64'(out_valid8), 64'd0);
    check("t5_idle_busy", 64'(busy8), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
